// File: rtl/simple_bus_reg_slave.sv
// simple_bus responder: small 32-bit register bank (ID, CTRL, STATUS, scratch)
// with programmable wait states and a registered one-cycle s_ready strobe.
module simple_bus_reg_slave #(
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hABCD_1234
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  s_addr,
   input  logic [31:0] s_wdata,
   input  logic        s_we,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [31:0] s_rdata,
   output logic        s_err,
   input  logic [31:0] status_in,
   output logic [31:0] ctrl_out
);

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [IDX_W-1:0]  ID_IDX          = IDX_W'(0);
   localparam logic [IDX_W-1:0]  CTRL_IDX        = IDX_W'(1);
   localparam logic [IDX_W-1:0]  STATUS_IDX      = IDX_W'(2);
   localparam logic [DATA_W-1:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;
   // Only meaningful when WAIT_CYCLES > 0; the wrap at zero is never loaded.
   localparam logic [CNT_W-1:0]  WAIT_LOAD       = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic              we;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t               state;
   state_t               next_state;
   req_t                 req_q;
   req_t                 req_cur;
   logic [CNT_W-1:0]     wait_cnt;
   logic [DATA_W-1:0]    regs [NUM_REGS];

   logic                 capture;
   logic                 wait_load;
   logic                 wait_dec;
   logic                 commit;
   logic                 in_range;
   logic                 wr_en;
   logic [REG_IDX_W-1:0] reg_sel;
   logic [DATA_W-1:0]    rd_word;

   // Byte-lane bits of the address carry no meaning for word registers.
   logic                 unused_addr_bits;
   assign unused_addr_bits = ^s_addr[1:0];

   // With zero wait states the response edge is also the capture edge.
   assign req_cur = capture ? req_t'{idx: s_addr[7:2], we: s_we, wdata: s_wdata} : req_q;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-cycle control.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      wait_load  = 1'b0;
      wait_dec   = 1'b0;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (s_valid) begin
               capture = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  next_state = ST_RESP;
                  commit     = 1'b1;
               end else begin
                  next_state = ST_WAIT;
                  wait_load  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (!s_valid) begin
               next_state = ST_IDLE;
            end else if (wait_cnt == '0) begin
               next_state = ST_RESP;
               commit     = 1'b1;
            end else begin
               wait_dec = 1'b1;
            end
         end
         ST_RESP: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Request latch and wait-state counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q    <= '0;
         wait_cnt <= '0;
      end else begin
         if (capture) begin
            req_q <= req_cur;
         end
         if (wait_load) begin
            wait_cnt <= WAIT_LOAD;
         end else if (wait_dec) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
      end
   end

   // Address decode and read mux.
   assign in_range = (32'(req_cur.idx) < NUM_REGS);
   assign reg_sel  = REG_IDX_W'(req_cur.idx);
   assign wr_en    = commit && req_cur.we && in_range &&
                     (req_cur.idx != ID_IDX) && (req_cur.idx != STATUS_IDX);

   always_comb begin
      rd_word = DECODE_ERR_DATA;
      if (in_range) begin
         case (req_cur.idx)
            ID_IDX:     rd_word = ID_VALUE;
            STATUS_IDX: rd_word = status_in;
            default:    rd_word = regs[reg_sel];
         endcase
      end
   end

   // Register bank: writes and status capture happen on the edge entering RESP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (reg_sel == REG_IDX_W'(i))) begin
               regs[i] <= req_cur.wdata;
            end
         end
         if (commit && !req_cur.we && (req_cur.idx == STATUS_IDX)) begin
            regs[STATUS_IDX[REG_IDX_W-1:0]] <= status_in;
         end
      end
   end

   // Response outputs; s_rdata holds across writes and idle cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_ready <= 1'b0;
         s_err   <= 1'b0;
         s_rdata <= '0;
      end else begin
         s_ready <= commit;
         s_err   <= commit && !in_range;
         if (commit && !req_cur.we) begin
            s_rdata <= rd_word;
         end
      end
   end

   assign ctrl_out = regs[CTRL_IDX[REG_IDX_W-1:0]];

endmodule
